// File: rtl/divider_ratio_detector_if.sv
// Signal bundle between a divided pulse source and the ratio detector.
interface divider_ratio_detector_if #(
  parameter int CNT_W = 5
);
  logic             pulse_in;
  logic [1:0]       sel_out;
  logic             locked;
  logic [CNT_W-1:0] period_out;
  logic             err_period;
  logic             err_timeout;

  modport master (
    output pulse_in,
    input  sel_out, locked, period_out, err_period, err_timeout
  );

  modport slave (
    input  pulse_in,
    output sel_out, locked, period_out, err_period, err_timeout
  );
endinterface

// File: rtl/divider_ratio_detector.sv
// Recovers the 2-bit divider select code from the spacing of rising edges on pulse_in;
// locks after two consecutive equal legal periods.
module divider_ratio_detector #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  divider_ratio_detector_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MEASURE, CAND, LOCK} state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_t           state, state_d;
  logic             prev;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       cand, cand_d;
  logic [1:0]       sel_q, sel_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             errp_q, errp_d;
  logic             errt_q, errt_d;

  logic             edge_det;
  logic             legal;
  logic [1:0]       code;
  logic             timeout_hit;

  assign edge_det    = bus.pulse_in & ~prev;
  // An edge in the saturation cycle is measured as a period, never a timeout.
  assign timeout_hit = (cnt == TMO) && !edge_det && (state != IDLE);

  always_comb begin
    legal = 1'b1;
    code  = 2'b00;
    case (cnt)
      CNT_W'(2): code = 2'b01;
      CNT_W'(3): code = 2'b00;
      CNT_W'(4): code = 2'b10;
      CNT_W'(8): code = 2'b11;
      default:   legal = 1'b0;
    endcase
  end

  always_comb begin
    cnt_d = cnt;
    if (edge_det)
      cnt_d = CNT_W'(1);
    else if (cnt != TMO)
      cnt_d = cnt + CNT_W'(1);
  end

  always_comb begin
    state_d  = state;
    cand_d   = cand;
    sel_d    = sel_q;
    locked_d = locked_q;
    period_d = period_q;
    errp_d   = 1'b0;
    errt_d   = 1'b0;

    if (edge_det && state != IDLE)
      period_d = cnt;

    case (state)
      IDLE: begin
        if (edge_det) state_d = MEASURE;
      end
      MEASURE: begin
        if (edge_det) begin
          if (legal) begin
            state_d = CAND;
            cand_d  = code;
          end else begin
            errp_d = 1'b1;
          end
        end
      end
      CAND: begin
        if (edge_det) begin
          if (legal && code == cand) begin
            state_d  = LOCK;
            sel_d    = cand;
            locked_d = 1'b1;
          end else if (legal) begin
            cand_d = code;
          end else begin
            state_d = MEASURE;
            errp_d  = 1'b1;
          end
        end
      end
      LOCK: begin
        if (edge_det) begin
          if (legal && code != cand) begin
            state_d  = CAND;
            cand_d   = code;
            locked_d = 1'b0;
          end else if (!legal) begin
            state_d  = MEASURE;
            locked_d = 1'b0;
            errp_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout_hit) begin
      state_d  = IDLE;
      locked_d = 1'b0;
      errt_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prev     <= 1'b1;
      cnt      <= '0;
      cand     <= '0;
      sel_q    <= '0;
      locked_q <= 1'b0;
      period_q <= '0;
      errp_q   <= 1'b0;
      errt_q   <= 1'b0;
    end else begin
      state    <= state_d;
      prev     <= bus.pulse_in;
      cnt      <= cnt_d;
      cand     <= cand_d;
      sel_q    <= sel_d;
      locked_q <= locked_d;
      period_q <= period_d;
      errp_q   <= errp_d;
      errt_q   <= errt_d;
    end
  end

  assign bus.sel_out     = sel_q;
  assign bus.locked      = locked_q;
  assign bus.period_out  = period_q;
  assign bus.err_period  = errp_q;
  assign bus.err_timeout = errt_q;

endmodule

// File: tb/tb_divider_ratio_detector.sv
// Scoreboard bench: per-cycle expected outputs from an edge-time/period-history model.
module tb_divider_ratio_detector;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  divider_ratio_detector_if #(.CNT_W(CNT_W)) bus ();

  divider_ratio_detector #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [1:0]       sel;
    logic             locked;
    logic [CNT_W-1:0] period;
    logic             errp;
    logic             errt;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;

  // Model: edges are timestamps; lock means the last two periods since leaving idle
  // are legal and equal; timeout when TIMEOUT cycles pass with no edge while active.
  bit         m_prev   = 1'b1;
  bit         m_active = 1'b0;
  int         m_cyc    = 0;
  int         m_last   = 0;
  int         per[$];
  logic [1:0] m_sel    = 2'b00;
  exp_t       m_out    = '0;

  function automatic bit legal_p(input int p);
    return (p == 2) || (p == 3) || (p == 4) || (p == 8);
  endfunction

  function automatic logic [1:0] code_of(input int p);
    case (p)
      2:       return 2'b01;
      3:       return 2'b00;
      4:       return 2'b10;
      8:       return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task model(input logic p, input logic r);
    bit e;
    int gap;
    int pm;
    if (r) begin
      m_prev   = 1'b1;
      m_active = 1'b0;
      per.delete();
      m_sel    = 2'b00;
      m_out    = '0;
    end else begin
      e      = p && !m_prev;
      m_prev = p;
      gap    = m_cyc - m_last;
      m_out.errp = 1'b0;
      m_out.errt = 1'b0;
      if (e) begin
        if (m_active) begin
          pm = (gap > TIMEOUT) ? TIMEOUT : gap;
          m_out.period = CNT_W'(pm);
          if (!legal_p(pm)) m_out.errp = 1'b1;
          per.push_back(pm);
          if (per.size() > 2) void'(per.pop_front());
          m_out.locked = (per.size() == 2) && legal_p(per[0]) && (per[0] == per[1]);
          if (m_out.locked) m_sel = code_of(per[1]);
        end else begin
          m_active = 1'b1;
          per.delete();
        end
        m_last = m_cyc;
      end else if (m_active && gap >= TIMEOUT) begin
        m_active     = 1'b0;
        m_out.locked = 1'b0;
        m_out.errt   = 1'b1;
      end
    end
    m_out.sel = m_sel;
    m_cyc++;
  endtask

  task step(input logic p, input logic r);
    @(negedge clk);
    bus.pulse_in = p;
    rst          = r;
    model(p, r);
    expq.push_back(m_out);
  endtask

  task pulses(input int n, input int reps, input int hi);
    for (int k = 0; k < reps; k++)
      for (int i = 0; i < n; i++)
        step(i < hi, 1'b0);
  endtask

  task hold(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v, 1'b0);
  endtask

  initial begin : monitor
    exp_t x;
    exp_t act;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        x   = expq.pop_front();
        act = {bus.sel_out, bus.locked, bus.period_out, bus.err_period, bus.err_timeout};
        tests++;
        if (act !== x) begin
          fails++;
          $display("FAIL outputs @%0t: got sel=%b locked=%b period=%0d errp=%b errt=%b, want sel=%b locked=%b period=%0d errp=%b errt=%b",
                   $time, act.sel, act.locked, act.period, act.errp, act.errt,
                   x.sel, x.locked, x.period, x.errp, x.errt);
        end
      end
    end
  end

  initial begin : stimulus
    int tbl[9] = '{2, 3, 4, 8, 5, 6, 7, 16, 9};
    int n;
    bus.pulse_in = 1'b1;
    // Held high through reset, then /2 lock
    repeat (3) step(1'b1, 1'b1);
    hold(1'b1, 4);
    pulses(2, 6 + $urandom_range(0, 5), 1);
    // /8 then /3 without reset
    pulses(8, 4, 1);
    pulses(3, 4, 1);
    // Illegal spacing of 5
    pulses(5, 5, 1);
    // /4 lock then input stuck low
    pulses(4, 4, 1);
    hold(1'b0, 25);
    // Reset pulse while locked on /2, then re-lock
    pulses(2, 5, 1);
    step(1'b1, 1'b1);
    pulses(2, 5, 1);
    // Edge exactly TIMEOUT cycles after the previous one
    pulses(4, 4, 1);
    step(1'b1, 1'b0);
    hold(1'b0, TIMEOUT - 1);
    pulses(4, 3, 1);
    hold(1'b0, 20);
    // Randomized mix of legal/illegal spacings, widths, resets and stalls
    repeat (300) begin
      n = tbl[$urandom_range(0, 8)];
      pulses(n, $urandom_range(1, 4), $urandom_range(1, n - 1));
      if ($urandom_range(0, 39) == 0) step(1'($urandom_range(0, 1)), 1'b1);
      if ($urandom_range(0, 19) == 0) hold(1'($urandom_range(0, 1)), $urandom_range(10, 25));
    end
    @(posedge clk);
    #2;
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, want 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
